instr_fetch_queue: RTL
======================

# instr_fetch_queue

Parametrised N-way instruction queue placed between the loader and the decoders in the instruction front end. It replaces the combinational `stop` stall with a registered buffer: up to WAYS instructions enter per cycle, with holes compacted out, and up to WAYS leave per cycle in program order. It provides backpressure to the loader, exposes occupancy, and is flushed in one cycle on a redirect.

## Interface

Parameters:
- `XLEN`, default 32: address width.
- `WAYS`, default 2: lanes per side, ≥1.
- `DEPTH`, default 8: entries; power of two; ≥ 2*WAYS.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `flush`  in  1  synchronous queue clear on redirect/mispredict.
- `in_valid`  in  WAYS  per-lane push request; any bit pattern is legal.
- `in_address`  in  WAYS×XLEN  per-lane instruction address.
- `in_instr`  in  WAYS×32  per-lane instruction word.
- `in_ready`  out  1  queue can accept a full WAYS group this cycle.
- `stop`  out  1  equals `!in_ready`; drives the loader hold.
- `out_valid`  out  WAYS  lane i holds the i-th oldest entry.
- `out_address`  out  WAYS×XLEN  entry addresses, oldest in lane 0.
- `out_instr`  out  WAYS×32  entry words, oldest in lane 0.
- `out_take`  in  $clog2(WAYS+1)  number of lanes the consumer accepts this cycle, taken from lane 0 upward.
- `count`  out  $clog2(DEPTH+1)  current occupancy.

## Operation

- **State:** storage array `mem[DEPTH]` of {address, instr}; `head` and `tail` pointers, each $clog2(DEPTH) bits, wrapping modulo DEPTH; `count` register.
- **`in_ready`:** `(DEPTH - count) >= WAYS`, computed from the registered `count` only. It never depends on same-cycle `out_take`, so there is no combinational path from consumer to loader.
- **Push:**
  - A push happens when `in_ready` is high and a lane's `in_valid` bit is set.
  - Valid lanes are written in lane order to `tail`, `tail+1`, …, with invalid lanes skipped (compaction). Lane i's slot is `tail + popcount(in_valid[i-1:0])`.
  - `tail` advances by `popcount(in_valid)`.
  - When `in_ready` is low, all lanes are ignored. The loader must hold its data.
- **Pop:**
  - `out_valid[i] = (i < count)`.
  - Lane i data is `mem[head+i]`, read combinationally from registers.
  - Effective pop count `n_pop = min(out_take, count, WAYS)`. Oversized `out_take` values are clamped, never underflow.
  - `head` advances by `n_pop`.
- **Simultaneous push and pop:** `count_next = count + n_push - n_pop`. Both pointers update independently. Popping never frees space for a push in the same cycle.
- **Flush/reset:**
  - Both set `head = tail = count = 0`.
  - Any push or pop in that cycle is discarded.
  - `reset` and `flush` are equivalent for queue state. `mem` contents are not cleared.
- **Arithmetic:**
  - Pointer adds truncate to $clog2(DEPTH) bits, which gives natural wrap.
  - `count` never exceeds DEPTH and never goes below 0. The `in_ready` rule guarantees the upper bound; the `n_pop` clamp guarantees the lower bound.
- **Ordering:** program order is preserved across lanes and across cycles. The oldest entry is always in `out_*` lane 0.

## Timing

- **Reset values:** `count=0`, `out_valid=0`, `in_ready=1`, `stop=0`. `out_address` and `out_instr` are don't-care while `out_valid=0`.
- **Latency:** a pushed entry is visible on `out_*` the cycle after it is written (1-cycle latency). There is no same-cycle bypass.
- **Pop effect:** a pop becomes visible one cycle later. The next entries shift into lane 0.
- **Stall timing:** `stop` rises the cycle after `count` exceeds DEPTH-WAYS. It falls the cycle after pops bring `count` to DEPTH-WAYS or below.
- **Flush/reset latency:** takes effect at the next edge. Outputs are empty the following cycle, and `in_ready=1`.
- **Boundary cases:**
  - Full queue (`count=DEPTH`): pops are allowed, pushes are blocked.
  - Empty queue: `out_take` is ignored.
  - Wrap-around is transparent to the output lane order.

## Test plan

WAYS=2, DEPTH=8 unless noted.

- **Reset then push:** after reset, push lanes {A0:0x100, A1:0x104} with `in_valid=11`. Next cycle: `out_valid=11`, `out_address={0x100,0x104}`, `count=2`.
- **Compaction:** push `in_valid=10` with lane1 = 0x200 into an empty queue. Next cycle: lane0 = 0x200, `out_valid=01`, `count=1`.
- **Fill and backpressure:** push 2 entries per cycle with `out_take=0` for 4 cycles. `count` reads 2, 4, 6, 8. `stop` is 1 once `count=8`. A 5th push is ignored and `count` stays 8.
- **Wrap-around with concurrent traffic:** hold `count=6` with `head=6`, then push 2 and take 2 each cycle for 8 cycles. Output addresses stay strictly sequential (step 4), `count` stays 6, and `in_ready` stays 1 because `count` ≤ DEPTH-WAYS.
- **Clamp:** with `count=1`, drive `out_take=2`. Next cycle: `count=0`, `out_valid=00`, no underflow.
- **Flush mid-operation:** with `count=5`, assert `flush` together with a push of 2 and `out_take=1`. Next cycle: `count=0`, `out_valid=00`, `in_ready=1`. A subsequent push of 0x300 appears in lane 0.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
// Registered N-way instruction queue between the loader and the decoders.
// Up to WAYS instructions enter per cycle with invalid lanes compacted out,
// and up to WAYS leave per cycle in program order (oldest in lane 0).
// Backpressure is derived from the registered occupancy only, so there is
// no combinational path from the consumer's take count to the loader hold.
module instr_fetch_queue #(
  parameter int XLEN  = 32,
  parameter int WAYS  = 2,
  parameter int DEPTH = 8
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              flush,
  input  logic [WAYS-1:0]                   in_valid,
  input  logic [WAYS-1:0][XLEN-1:0]         in_address,
  input  logic [WAYS-1:0][31:0]             in_instr,
  output logic                              in_ready,
  output logic                              stop,
  output logic [WAYS-1:0]                   out_valid,
  output logic [WAYS-1:0][XLEN-1:0]         out_address,
  output logic [WAYS-1:0][31:0]             out_instr,
  input  logic [$clog2(WAYS+1)-1:0]         out_take,
  output logic [$clog2(DEPTH+1)-1:0]        count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int TAKE_W = $clog2(WAYS + 1);

  // Highest occupancy at which a full WAYS-wide group still fits.
  localparam logic [CNT_W-1:0]  READY_MAX = CNT_W'(DEPTH - WAYS);
  localparam logic [TAKE_W-1:0] WAYS_CNT  = TAKE_W'(WAYS);

  typedef struct packed {
    logic [XLEN-1:0] address;
    logic [31:0]     instr;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count_q;

  logic                        clear;
  logic                        push_en;
  logic [WAYS-1:0][TAKE_W-1:0] lane_ofs;
  logic [WAYS-1:0][PTR_W-1:0]  wr_slot;
  logic [TAKE_W-1:0]           n_push;
  logic [TAKE_W-1:0]           n_push_eff;
  logic [TAKE_W-1:0]           take_clamp;
  logic [TAKE_W-1:0]           n_pop;

  // Reset and flush clear the pointers identically; both discard any
  // push or pop presented in the same cycle.
  assign clear = reset | flush;

  // Space for a whole group is judged from registered occupancy alone.
  assign in_ready = (count_q <= READY_MAX);
  assign stop     = ~in_ready;
  assign count    = count_q;
  assign push_en  = in_ready & ~clear;

  // Compaction: each valid lane lands at tail plus the number of valid
  // lanes below it, so holes in in_valid never occupy storage.
  always_comb begin
    logic [TAKE_W-1:0] acc;
    // NOTE: combinational blocks use blocking '=' and assign every output
    // up front so no path through the block can infer a latch.
    acc      = '0;
    lane_ofs = '0;
    wr_slot  = '0;
    for (int i = 0; i < WAYS; i++) begin
      lane_ofs[i] = acc;
      wr_slot[i]  = tail + PTR_W'(acc);
      acc         = acc + TAKE_W'(in_valid[i]);
    end
    n_push = acc;
  end

  assign n_push_eff = push_en ? n_push : '0;

  // Pop count is clamped to both the lane count and the occupancy, so an
  // oversized take or a take on an empty queue can never underflow.
  always_comb begin
    take_clamp = (out_take > WAYS_CNT) ? WAYS_CNT : out_take;
    if (CNT_W'(take_clamp) > count_q) n_pop = TAKE_W'(count_q);
    else                              n_pop = take_clamp;
    if (clear) n_pop = '0;
  end

  // Pointer and occupancy update; pointer adds wrap naturally at DEPTH.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking '<=' so every register
    // samples the pre-edge values regardless of statement order.
    if (clear) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      head    <= head + PTR_W'(n_pop);
      tail    <= tail + PTR_W'(n_push_eff);
      count_q <= count_q + CNT_W'(n_push_eff) - CNT_W'(n_pop);
    end
  end

  // Storage write for each accepted lane at its compacted slot.
  always_ff @(posedge clock) begin
    // NOTE: the storage array is deliberately not reset; occupancy
    // tracking alone decides which entries are meaningful.
    for (int i = 0; i < WAYS; i++) begin
      if (push_en && in_valid[i]) begin
        mem[wr_slot[i]] <= '{address: in_address[i], instr: in_instr[i]};
      end
    end
  end

  // Output lanes present the oldest entries in order, straight from storage.
  always_comb begin
    logic [PTR_W-1:0] rd_ptr;
    rd_ptr      = '0;
    out_valid   = '0;
    out_address = '0;
    out_instr   = '0;
    for (int i = 0; i < WAYS; i++) begin
      rd_ptr         = head + PTR_W'(i);
      out_valid[i]   = (CNT_W'(i) < count_q);
      out_address[i] = mem[rd_ptr].address;
      out_instr[i]   = mem[rd_ptr].instr;
    end
  end

endmodule
